// File: rtl/fault_injector_if.sv
// fault_injector_if
// Groups the control, configuration and status signals of the fault-pulse
// generator into one bundle.
//   master : drives start/abort and the burst configuration, observes status
//   slave  : the generator itself, consumes control and drives status
// Ports carried:
//   start, abort                    - burst request / cancel
//   pulse_len, gap_len (LEN_W)      - high cycles per pulse, low cycles between
//   num_pulses (NUM_W)              - pulses per burst
//   fault_out, busy, done           - generated fault line and status strobes
//   pulse_cnt (NUM_W)               - pulses fully emitted in current/last burst
interface fault_injector_if #(
    parameter int LEN_W = 10,
    parameter int NUM_W = 8
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] pulse_len;
    logic [LEN_W-1:0] gap_len;
    logic [NUM_W-1:0] num_pulses;
    logic             fault_out;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulse_cnt;

    modport master (
        output start, abort, pulse_len, gap_len, num_pulses,
        input  fault_out, busy, done, pulse_cnt
    );

    modport slave (
        input  start, abort, pulse_len, gap_len, num_pulses,
        output fault_out, busy, done, pulse_cnt
    );
endinterface

// File: rtl/fault_injector.sv
// fault_injector
// Programmable fault-pulse generator. On start it emits num_pulses high
// pulses of pulse_len cycles, separated by max(gap_len,1) low cycles, then
// strobes done for one cycle. abort cancels an active burst without done.
// Ports:
//   clk   - single rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - fault_injector_if slave modport (control, config, status)
// All outputs come straight from flops.
module fault_injector #(
    parameter int LEN_W = 10,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    fault_injector_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic [LEN_W-1:0] pulse_len_q, pulse_len_d;
    logic [LEN_W-1:0] gap_len_q, gap_len_d;
    logic [NUM_W-1:0] num_pulses_q, num_pulses_d;
    logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             fault_out_q, fault_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // A zero gap still leaves one low cycle so consecutive pulses never merge.
    logic [LEN_W-1:0] gap_target;
    assign gap_target = (gap_len_q == '0) ? LEN_W'(1) : gap_len_q;

    // Next-state and next-output logic. Outputs are computed one cycle early
    // so that fault_out/busy/done can be registered and still line up with
    // the state they describe.
    always_comb begin
        state_d      = state_q;
        len_cnt_d    = len_cnt_q;
        pulse_len_d  = pulse_len_q;
        gap_len_d    = gap_len_q;
        num_pulses_d = num_pulses_q;
        pulse_cnt_d  = pulse_cnt_q;
        fault_out_d  = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pulse_len_d  = bus.pulse_len;
                    gap_len_d    = bus.gap_len;
                    num_pulses_d = bus.num_pulses;
                    pulse_cnt_d  = '0;
                    if (bus.pulse_len == '0 || bus.num_pulses == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = PULSE;
                        fault_out_d = 1'b1;
                        busy_d      = 1'b1;
                        len_cnt_d   = LEN_W'(1);
                    end
                end
            end

            PULSE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (len_cnt_q == pulse_len_q) begin
                    // Last high cycle of this pulse: it now counts as emitted.
                    pulse_cnt_d = pulse_cnt_q + NUM_W'(1);
                    if (pulse_cnt_q + NUM_W'(1) == num_pulses_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = GAP;
                        busy_d    = 1'b1;
                        len_cnt_d = LEN_W'(1);
                    end
                end else begin
                    len_cnt_d   = len_cnt_q + LEN_W'(1);
                    fault_out_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (len_cnt_q == gap_target) begin
                    state_d     = PULSE;
                    fault_out_d = 1'b1;
                    busy_d      = 1'b1;
                    len_cnt_d   = LEN_W'(1);
                end else begin
                    len_cnt_d = len_cnt_q + LEN_W'(1);
                    busy_d    = 1'b1;
                end
            end

            DONE: begin
                // start is deliberately not looked at here; a held start
                // launches the next burst from IDLE one cycle later.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, latched configuration and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            len_cnt_q    <= '0;
            pulse_len_q  <= '0;
            gap_len_q    <= '0;
            num_pulses_q <= '0;
            pulse_cnt_q  <= '0;
            fault_out_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_cnt_q    <= len_cnt_d;
            pulse_len_q  <= pulse_len_d;
            gap_len_q    <= gap_len_d;
            num_pulses_q <= num_pulses_d;
            pulse_cnt_q  <= pulse_cnt_d;
            fault_out_q  <= fault_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.fault_out = fault_out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_fault_injector.sv
// tb_fault_injector
// Self-checking bench for fault_injector. A reference model turns each
// accepted start into the full expected per-cycle waveform (a queue of
// output records) from the burst rules, and every cycle the DUT outputs
// are compared against the head of that waveform.
module tb_fault_injector;

    logic clk;
    logic reset;

    fault_injector_if #(.LEN_W(10), .NUM_W(8)) bus ();

    fault_injector #(.LEN_W(10), .NUM_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       f;
        logic       b;
        logic       d;
        logic [7:0] c;
    } exp_t;

    exp_t  expq[$];
    exp_t  cur;
    int    testCount;
    int    failCount;
    int    cyc;
    string phase;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expand one burst into its expected output waveform, one record per
    // cycle after the start edge, ending with the done cycle.
    task automatic buildBurst(input logic [9:0] p, input logic [9:0] g, input logic [7:0] n);
        int gmin;
        gmin = (g == 0) ? 1 : int'(g);
        if (p == 0 || n == 0) begin
            expq.push_back('{f: 1'b0, b: 1'b0, d: 1'b1, c: 8'd0});
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                for (int j = 0; j < int'(p); j++)
                    expq.push_back('{f: 1'b1, b: 1'b1, d: 1'b0, c: 8'(i)});
                if (i < int'(n) - 1)
                    for (int j = 0; j < gmin; j++)
                        expq.push_back('{f: 1'b0, b: 1'b1, d: 1'b0, c: 8'(i + 1)});
            end
            expq.push_back('{f: 1'b0, b: 1'b0, d: 1'b1, c: n});
        end
    endtask

    // Advance the reference model across one clock edge.
    task automatic modelStep(input logic st, input logic ab, input logic [9:0] p,
                             input logic [9:0] g, input logic [7:0] n);
        if (cur.b && ab) begin
            expq.delete();
            cur = '{f: 1'b0, b: 1'b0, d: 1'b0, c: cur.c};
        end else if (expq.size() > 0) begin
            cur = expq.pop_front();
        end else if (cur.d) begin
            cur = '{f: 1'b0, b: 1'b0, d: 1'b0, c: cur.c};
        end else if (st) begin
            buildBurst(p, g, n);
            cur = expq.pop_front();
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput($sformatf("%s/fault_out@%0d", tag, cyc), 32'(bus.fault_out), 32'(cur.f));
        checkOutput($sformatf("%s/busy@%0d", tag, cyc), 32'(bus.busy), 32'(cur.b));
        checkOutput($sformatf("%s/done@%0d", tag, cyc), 32'(bus.done), 32'(cur.d));
        checkOutput($sformatf("%s/pulse_cnt@%0d", tag, cyc), 32'(bus.pulse_cnt), 32'(cur.c));
    endtask

    // Drive one cycle of inputs (called at a falling edge), let the DUT and
    // model take the rising edge, then compare at the next falling edge.
    task automatic applyStimulus(input logic st, input logic ab, input logic [9:0] p,
                                 input logic [9:0] g, input logic [7:0] n);
        bus.start      = st;
        bus.abort      = ab;
        bus.pulse_len  = p;
        bus.gap_len    = g;
        bus.num_pulses = n;
        @(posedge clk);
        modelStep(st, ab, p, g, n);
        @(negedge clk);
        cyc++;
        checkAll(phase);
    endtask

    task automatic idleCycles(input int k, input logic [9:0] p, input logic [9:0] g, input logic [7:0] n);
        for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, p, g, n);
    endtask

    task automatic runBurst(input string name, input logic [9:0] p, input logic [9:0] g,
                            input logic [7:0] n, input int tail);
        phase = name;
        applyStimulus(1'b1, 1'b0, p, g, n);
        idleCycles(tail, p, g, n);
    endtask

    initial begin
        testCount      = 0;
        failCount      = 0;
        cyc            = 0;
        cur            = '{f: 1'b0, b: 1'b0, d: 1'b0, c: 8'd0};
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pulse_len  = '0;
        bus.gap_len    = '0;
        bus.num_pulses = '0;
        reset          = 1'b0;
        #1 reset = 1'b1;
        #2;
        phase = "reset";
        checkAll(phase);
        @(negedge clk);
        reset = 1'b0;
        phase = "post_reset_idle";
        idleCycles(3, 10'd3, 10'd2, 8'd1);

        // Directed bursts from the burst rules.
        runBurst("p3g2n1", 10'd3, 10'd2, 8'd1, 6);
        runBurst("p2g4n3", 10'd2, 10'd4, 8'd3, 16);
        runBurst("p1g0n4", 10'd1, 10'd0, 8'd4, 9);
        runBurst("p0n3", 10'd0, 10'd2, 8'd3, 3);
        runBurst("p4n0", 10'd4, 10'd2, 8'd0, 3);

        // Abort in the third pulse: two full pulses plus two gaps, then
        // four cycles into pulse three.
        runBurst("abort", 10'd10, 10'd3, 8'd5, 26 + 3);
        applyStimulus(1'b0, 1'b1, 10'd10, 10'd3, 8'd5);
        checkOutput("abort_pulse_cnt", 32'(bus.pulse_cnt), 32'd2);
        idleCycles(4, 10'd10, 10'd3, 8'd5);
        runBurst("after_abort", 10'd2, 10'd1, 8'd2, 8);

        // start and abort together in IDLE: start wins.
        phase = "start_abort_idle";
        applyStimulus(1'b1, 1'b1, 10'd2, 10'd1, 8'd1);
        idleCycles(4, 10'd2, 10'd1, 8'd1);

        // start held high: back-to-back bursts, one per IDLE visit.
        phase = "held_start";
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 10'd1, 10'd0, 8'd2);
        idleCycles(4, 10'd1, 10'd0, 8'd2);

        // Asynchronous reset in the middle of a pulse.
        runBurst("reset_mid", 10'd10, 10'd2, 8'd2, 4);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst/fault_out", 32'(bus.fault_out), 32'd0);
        checkOutput("async_rst/busy", 32'(bus.busy), 32'd0);
        checkOutput("async_rst/done", 32'(bus.done), 32'd0);
        checkOutput("async_rst/pulse_cnt", 32'(bus.pulse_cnt), 32'd0);
        expq.delete();
        cur = '{f: 1'b0, b: 1'b0, d: 1'b0, c: 8'd0};
        @(negedge clk);
        reset = 1'b0;
        phase = "after_reset";
        idleCycles(6, 10'd10, 10'd2, 8'd2);

        // Randomised run: configuration wanders every cycle, sporadic start
        // and abort requests.
        phase = "rnd";
        for (int i = 0; i < 1500; i++) begin
            logic       st;
            logic       ab;
            logic [9:0] p;
            logic [9:0] g;
            logic [7:0] n;
            st = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 29) == 0);
            p  = 10'($urandom_range(0, 6));
            g  = 10'($urandom_range(0, 4));
            n  = 8'($urandom_range(0, 4));
            applyStimulus(st, ab, p, g, n);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
